// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pkg
//  Brief    : Shared types, counter widths and beat-count helper for the
//             parametrised 16-bit asynchronous SRAM controller.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_ADDR = 3'd2,
        READ      = 3'd3,
        STALL     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Beat index covers up to 8 beats (DATA_W = 128)
    localparam int c_BEAT_CNT_W = 3;
    // Recovery counter covers WAIT_CYCLES up to 15
    localparam int c_WAIT_CNT_W = 4;

    // Number of 16-bit SRAM beats needed for one CPU word
    function automatic int n_beats(input int data_w);
        return data_w / 16;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_param_if
//  Brief    : CPU-side request/response bundle of the SRAM controller.
//             The byteEn mask only exists when SRAM_BYTEMASK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_ctrl_param_if #(
    parameter int DATA_W = 32
);
    logic                wrEn;
    logic                rdEn;
    logic [31:0]         address;
    logic [DATA_W-1:0]   writeData;
`ifdef SRAM_BYTEMASK_EN
    logic [DATA_W/8-1:0] byteEn;
`endif
    logic [DATA_W-1:0]   readData;
    logic                ready;

`ifdef SRAM_BYTEMASK_EN
    modport master (output wrEn, rdEn, address, writeData, byteEn,
                    input  readData, ready);
    modport slave  (input  wrEn, rdEn, address, writeData, byteEn,
                    output readData, ready);
`else
    modport master (output wrEn, rdEn, address, writeData,
                    input  readData, ready);
    modport slave  (input  wrEn, rdEn, address, writeData,
                    output readData, ready);
`endif
endinterface
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_wait_counter
//  Brief    : Loadable down-counter with a terminal (zero) flag, used to time
//             the recovery cycles that follow each SRAM access.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_param
//  Brief    : Splits a DATA_W-bit CPU access into DATA_W/16 beats on a 16-bit
//             asynchronous SRAM, rebased by BASE_ADDR, followed by
//             WAIT_CYCLES recovery cycles and a one-cycle ready pulse.
//             Optional macro SRAM_BYTEMASK_EN adds per-byte write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl_param
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_ctrl_param_if.slave       bus,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int                      c_N         = n_beats(DATA_W);
    localparam logic [c_BEAT_CNT_W-1:0] c_LAST_BEAT = c_BEAT_CNT_W'(c_N - 1);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD =
        c_WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    // A word access always starts on a word boundary
    localparam logic [31:0]             c_ALIGN_MASK = ~32'(DATA_W / 8 - 1);
    localparam state_t                  c_AFTER_BEATS = (WAIT_CYCLES > 0) ? STALL : DONE;

    state_t                  state_q;
    logic [c_BEAT_CNT_W-1:0] beat_q;
    logic [SRAM_ADDR_W-1:0]  base_q;
    logic [SRAM_ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rslot_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    we_n_q;
    logic [15:0]             dq_out_q;
    logic [15:0]             dq_in_q;

    logic [31:0]             w_off;
    logic [SRAM_ADDR_W-1:0]  w_base;
    logic [SRAM_ADDR_W-1:0]  w_addr_plus1;
    logic [SRAM_ADDR_W-1:0]  w_addr_plus2;
    logic                    w_last;
    logic [c_BEAT_CNT_W-1:0] w_wsel;
    logic [DATA_W-1:0]       w_wsrc;
    logic [15:0]             w_wbeat;
    logic [DATA_W-1:0]       w_rword;
    logic                    w_wait_load;
    logic                    w_wait_dec;
    logic                    w_wait_zero;

    // Rebased, word-aligned halfword address of the incoming request
    assign w_off  = (bus.address - 32'(BASE_ADDR)) & c_ALIGN_MASK;
    assign w_base = SRAM_ADDR_W'(w_off >> 1);

    // Beat addresses wrap modulo the SRAM size
    assign w_addr_plus1 = base_q + SRAM_ADDR_W'(beat_q) + SRAM_ADDR_W'(1);
    assign w_addr_plus2 = base_q + SRAM_ADDR_W'(beat_q) + SRAM_ADDR_W'(2);
    assign w_last       = (beat_q == c_LAST_BEAT);

    // Beat 0 is launched straight from the request; later beats from the latch
    assign w_wsel  = (state_q == IDLE) ? '0 : (beat_q + c_BEAT_CNT_W'(1));
    assign w_wsrc  = (state_q == IDLE) ? bus.writeData : wdata_q;
    assign w_wbeat = w_wsrc[16*w_wsel +: 16];

`ifdef SRAM_BYTEMASK_EN
    logic [DATA_W/8-1:0] be_q;
    logic                ub_n_q;
    logic                lb_n_q;
    logic [DATA_W/8-1:0] w_besrc;
    logic                w_ub_n;
    logic                w_lb_n;

    assign w_besrc = (state_q == IDLE) ? bus.byteEn : be_q;
    assign w_ub_n  = ~w_besrc[2*w_wsel + 1];
    assign w_lb_n  = ~w_besrc[2*w_wsel];
`endif

    // Read word with the current beat slot replaced by the captured halfword
    always_comb begin
        w_rword                   = rslot_q;
        w_rword[16*beat_q +: 16]  = dq_in_q;
    end

    assign w_wait_load = ((state_q == WRITE) || (state_q == READ)) && w_last;
    assign w_wait_dec  = (state_q == STALL);

    sram_wait_counter #(
        .WIDTH (c_WAIT_CNT_W)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_wait_load),
        .load_val_i (c_WAIT_LOAD),
        .dec_i      (w_wait_dec),
        .zero_o     (w_wait_zero)
    );

    // Sequencer with registered SRAM strobes; the address shown in a cycle
    // was set up on the previous edge, and DQ is registered one cycle later,
    // so each halfword gets a full clock of access time before it is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rslot_q  <= '0;
            rdata_q  <= '0;
            we_n_q   <= 1'b1;
            dq_out_q <= '0;
            dq_in_q  <= '0;
`ifdef SRAM_BYTEMASK_EN
            be_q     <= '0;
            ub_n_q   <= 1'b0;
            lb_n_q   <= 1'b0;
`endif
        end else begin
            dq_in_q <= SRAM_DQ;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
`ifdef SRAM_BYTEMASK_EN
            ub_n_q  <= 1'b0;
            lb_n_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.wrEn) begin
                        state_q  <= WRITE;
                        beat_q   <= '0;
                        base_q   <= w_base;
                        wdata_q  <= bus.writeData;
                        addr_q   <= w_base;
                        we_n_q   <= 1'b0;
                        dq_out_q <= w_wbeat;
`ifdef SRAM_BYTEMASK_EN
                        be_q     <= bus.byteEn;
                        ub_n_q   <= w_ub_n;
                        lb_n_q   <= w_lb_n;
`endif
                    end else if (bus.rdEn) begin
                        state_q <= READ_ADDR;
                        beat_q  <= '0;
                        base_q  <= w_base;
                        addr_q  <= w_base;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        state_q <= c_AFTER_BEATS;
                    end else begin
                        beat_q   <= beat_q + c_BEAT_CNT_W'(1);
                        addr_q   <= w_addr_plus1;
                        we_n_q   <= 1'b0;
                        dq_out_q <= w_wbeat;
`ifdef SRAM_BYTEMASK_EN
                        ub_n_q   <= w_ub_n;
                        lb_n_q   <= w_lb_n;
`endif
                    end
                end
                READ_ADDR: begin
                    state_q <= READ;
                    if (c_N > 1) begin
                        addr_q <= w_addr_plus1;
                    end
                end
                READ: begin
                    rslot_q <= w_rword;
                    if (w_last) begin
                        rdata_q <= w_rword;
                        state_q <= c_AFTER_BEATS;
                    end else begin
                        beat_q <= beat_q + c_BEAT_CNT_W'(1);
                        if ((int'(beat_q) + 2) < c_N) begin
                            addr_q <= w_addr_plus2;
                        end
                    end
                end
                STALL: begin
                    if (w_wait_zero) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ((state_q == IDLE) && !bus.wrEn && !bus.rdEn) ||
                          (state_q == DONE);
    assign bus.readData = rdata_q;

    assign SRAM_DQ   = we_n_q ? 16'bz : dq_out_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
`ifdef SRAM_BYTEMASK_EN
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;
`else
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sram_ctrl_param.md
# sram_ctrl_param

Parametrised SRAM controller between the ARM memory stage and the off-chip 16-bit asynchronous SRAM. It splits one DATA_W-bit word access into DATA_W/16 sequential SRAM beats and rebases the CPU byte address by BASE_ADDR. It inserts WAIT_CYCLES recovery cycles after each access and reports completion with a single-cycle `ready` pulse. Request fields are latched on accept, and read data is registered and held.

## Interface
Parameters:
- DATA_W, 32: CPU word width; multiple of 16, range 16..128. N = DATA_W/16 beats.
- SRAM_ADDR_W, 18: SRAM halfword address width.
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- WAIT_CYCLES, 3: recovery cycles after the last beat; 0..15, 0 skips STALL.

Ports:
- clk  in  1  single clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- wrEn  in  1  write request; held until `ready`.
- rdEn  in  1  read request; held until `ready`.
- address  in  32  byte address.
- writeData  in  DATA_W  write word.
- byteEn  in  DATA_W/8  byte write mask; exists only with SRAM_BYTEMASK_EN.
- readData  out  DATA_W  last read word, registered.
- ready  out  1  idle or access complete.
- SRAM_DQ  inout  16  data bus; high-Z except during write beats.
- SRAM_ADDR  out  SRAM_ADDR_W  halfword address.
- SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1  active-low SRAM strobes.

## Operation
- Base address: sramAddr = ((address − BASE_ADDR) >> 1) truncated to SRAM_ADDR_W, with the low log2(DATA_W/8) byte bits forced to 0.
- Beat address: beat j uses sramAddr + j, modulo 2^SRAM_ADDR_W; it wraps silently.
- Accept: occurs in IDLE when wrEn or rdEn is high. address, writeData and byteEn are latched.
- Priority: wrEn wins when wrEn and rdEn are both high.
- States:
  - IDLE: on wrEn → WRITE; on rdEn → READ_ADDR.
  - WRITE: N beats. Beat j drives writeData[16j+15:16j] on SRAM_DQ, WE_N = 0, address = sramAddr + j.
  - READ_ADDR: drives sramAddr.
  - READ: N beats. Beat j drives sramAddr + j + 1 while j < N−1. SRAM_DQ is sampled into beat slot j at the end of the cycle.
  - STALL: WAIT_CYCLES cycles, counted by the wait counter. WRITE and READ go to STALL, or to DONE if WAIT_CYCLES = 0.
  - DONE: one cycle, always → IDLE.
- readData loads the assembled word at the end of the last READ beat and is held until the next read completes.
- ready = (IDLE and no request) or DONE. A request still asserted during DONE is not re-accepted.
- Outside active beats: SRAM_ADDR = 0, WE_N = 1, DQ = Z.
- CE_N and OE_N are tied 0.

## Timing
- Cycle 0 = accept cycle.
- Write: beats in cycles 1..N; DONE in cycle N+WAIT_CYCLES+1.
- Read: READ_ADDR in cycle 1; beats in cycles 2..N+1; readData valid from cycle N+2; DONE in cycle N+WAIT_CYCLES+2.
- Defaults (N = 2, WAIT = 3): write ready in cycle 6, read ready in cycle 7.
- Reset, including mid-access: state → IDLE, readData = 0, WE_N = 1, DQ = Z, SRAM_ADDR = 0, UB_N/LB_N = 0, counters cleared.
- ready is 1 in the first cycle after reset if no request is present.
- The SRAM is asynchronous; one full clock between address and sample is guaranteed by the read sequencing.

## Configuration
- SRAM_BYTEMASK_EN defined:
  - The byteEn port exists.
  - Write beat j drives UB_N = ~byteEn[2j+1] and LB_N = ~byteEn[2j].
  - A beat with both enables low still runs, with WE_N = 0 and both byte strobes high.
  - Reads drive UB_N = LB_N = 0.
- SRAM_BYTEMASK_EN undefined: no byteEn port; UB_N and LB_N are tied 0.

## Structure
- Package sram_ctrl_pkg:
  - state encoding constants: IDLE, WRITE, READ_ADDR, READ, STALL, DONE;
  - beat-count function N(DATA_W);
  - width constants for the beat and wait counters.
- Sub-module sram_wait_counter: loadable down-counter with terminal flag. Used for STALL; the beat index is a separate small counter in the top.

## Test plan
- Default params, write 0xDEADBEEF at 0x408: beats at SRAM_ADDR 0x004 (DQ 0xBEEF, WE_N = 0) and 0x005 (0xDEAD); ready pulses in cycle 6.
- Read back 0x408 with the model returning the stored data: readData = 0xDEADBEEF from cycle 4; ready in cycle 7; readData held through a following write.
- wrEn and rdEn both high at IDLE: write sequence executes, readData unchanged.
- DATA_W = 64, WAIT_CYCLES = 0, read at BASE_ADDR + 0x7FFF8 with SRAM_ADDR_W = 18: beat addresses 0x3FFFC..0x3FFFF; ready in cycle 6.
- rst asserted in cycle 2 of a write: next cycle WE_N = 1, DQ = Z, readData = 0, ready = 1.
- SRAM_BYTEMASK_EN, byteEn = 4'b0110: beat 0 UB_N = 0, LB_N = 1; beat 1 UB_N = 1, LB_N = 0.
